// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the ID/EX operand stage (registered fields, forward select, ALU no-op code).
package riscv_pkg;
    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int REG_W  = 5;
    localparam logic [OP_W-1:0] ALU_NOP = 4'b0000;
    typedef enum logic [1:0] {FWD_NONE, FWD_EXMEM, FWD_MEMWB} fwd_sel_e;
    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic              alu_src;
        logic [OP_W-1:0]   alu_op;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
    } id_ex_t;
endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// fwd_mux: selects one ALU operand from EX/MEM, MEM/WB or register data; x0 never forwards.
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [DATA_WIDTH-1:0] rf_data_i,
    input  logic [REG_ADDR_W-1:0] exmem_rd_i,
    input  logic                  exmem_reg_write_i,
    input  logic [DATA_WIDTH-1:0] exmem_result_i,
    input  logic [REG_ADDR_W-1:0] memwb_rd_i,
    input  logic                  memwb_reg_write_i,
    input  logic [DATA_WIDTH-1:0] memwb_result_i,
    output logic [DATA_WIDTH-1:0] operand_o
);
    fwd_sel_e sel;
    always_comb begin
        sel = (exmem_reg_write_i && exmem_rd_i != '0 && exmem_rd_i == rs_i) ? FWD_EXMEM :
              (memwb_reg_write_i && memwb_rd_i != '0 && memwb_rd_i == rs_i) ? FWD_MEMWB : FWD_NONE;
        operand_o = (sel == FWD_EXMEM) ? exmem_result_i :
                    (sel == FWD_MEMWB) ? memwb_result_i : rf_data_i;
    end
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with load-use bubble insertion and per-operand forwarding into the ALU.
module id_ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hold,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic [REG_ADDR_W-1:0]    id_rs1,
    input  logic [REG_ADDR_W-1:0]    id_rs2,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic                     id_uses_rs2,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic                     id_alu_src,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     id_reg_write,
    input  logic [REG_ADDR_W-1:0]    exmem_rd,
    input  logic                     exmem_reg_write,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic [REG_ADDR_W-1:0]    memwb_rd,
    input  logic                     memwb_reg_write,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    output logic                     stall_o,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic                     ex_valid,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic                     ex_reg_write
);
    id_ex_t ex_q, ex_d;
    logic load_use;
    logic [DATA_WIDTH-1:0] rs2_fwd;
    assign load_use = ex_q.valid && ex_q.mem_read && ex_q.rd != '0 && id_valid &&
                      (ex_q.rd == id_rs1 || (id_uses_rs2 && ex_q.rd == id_rs2));
    assign stall_o = load_use && !flush;
    // hold freezes everything, including a pending flush; all other cases either bubble or capture
    always_comb begin
        ex_d = ex_q;
        if (!hold) begin
            ex_d = '0;
            ex_d.alu_op = ALU_NOP;
            if (!flush && !load_use && id_valid)
                ex_d = '{valid: 1'b1, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                         rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                         alu_src: id_alu_src, alu_op: id_alu_op, mem_read: id_mem_read,
                         mem_write: id_mem_write, reg_write: id_reg_write};
        end
    end
    always_ff @(posedge clk) ex_q <= reset ? '0 : ex_d;
    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs_i(ex_q.rs1), .rf_data_i(ex_q.rs1_data),
        .exmem_rd_i(exmem_rd), .exmem_reg_write_i(exmem_reg_write), .exmem_result_i(exmem_result),
        .memwb_rd_i(memwb_rd), .memwb_reg_write_i(memwb_reg_write), .memwb_result_i(memwb_result),
        .operand_o(SrcA)
    );
    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs_i(ex_q.rs2), .rf_data_i(ex_q.rs2_data),
        .exmem_rd_i(exmem_rd), .exmem_reg_write_i(exmem_reg_write), .exmem_result_i(exmem_result),
        .memwb_rd_i(memwb_rd), .memwb_reg_write_i(memwb_reg_write), .memwb_result_i(memwb_result),
        .operand_o(rs2_fwd)
    );
    assign ex_store_data = rs2_fwd;
    assign SrcB          = ex_q.alu_src ? ex_q.imm : rs2_fwd;
    assign Operation     = ex_q.alu_op;
    assign ex_valid      = ex_q.valid;
    assign ex_rd         = ex_q.rd;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_reg_write  = ex_q.reg_write;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed and random stimulus checked every cycle against a behavioural pipeline model.
module tb_id_ex_operand_stage;
    logic        clk = 0, reset, hold, flush, id_valid, id_uses_rs2, id_alu_src;
    logic [4:0]  id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd, ex_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_result;
    logic [3:0]  id_alu_op, Operation;
    logic        id_mem_read, id_mem_write, id_reg_write, exmem_reg_write, memwb_reg_write;
    logic        stall_o, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [31:0] SrcA, SrcB, ex_store_data;
    int n_cmp = 0, n_bad = 0;
    bit started = 0;

    id_ex_operand_stage dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .stall_o(stall_o), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write)
    );

    always #5 clk = ~clk;

    // model of the instruction currently in EX
    logic        m_v, m_src, m_mr, m_mw, m_rw;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_d1, m_d2, m_imm;
    logic [3:0]  m_op;

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (rs != 0 && exmem_reg_write && exmem_rd == rs) return exmem_result;
        if (rs != 0 && memwb_reg_write && memwb_rd == rs) return memwb_result;
        return rf;
    endfunction

    function automatic logic m_load_use();
        return m_v && m_mr && m_rd != 0 && id_valid &&
               (m_rd == id_rs1 || (id_uses_rs2 && m_rd == id_rs2));
    endfunction

    function automatic logic [109:0] model_vec();
        return {m_load_use() && !flush, fwd(m_rs1, m_d1), m_src ? m_imm : fwd(m_rs2, m_d2),
                m_op, fwd(m_rs2, m_d2), m_v, m_rd, m_mr, m_mw, m_rw};
    endfunction

    wire [109:0] dut_vec = {stall_o, SrcA, SrcB, Operation, ex_store_data,
                            ex_valid, ex_rd, ex_mem_read, ex_mem_write, ex_reg_write};

    always @(posedge clk) begin
        if (reset || (!hold && (flush || m_load_use() || !id_valid))) begin
            {m_v, m_src, m_mr, m_mw, m_rw, m_rs1, m_rs2, m_rd, m_d1, m_d2, m_imm, m_op} = '0;
        end else if (!hold) begin
            m_v = 1; m_src = id_alu_src; m_mr = id_mem_read; m_mw = id_mem_write; m_rw = id_reg_write;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm; m_op = id_alu_op;
        end
        started = 1;
    end

    task automatic check(input string n, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) if (started) check("cycle", 128'(dut_vec), 128'(model_vec()));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [4:0] r1, r2, rd, input logic u2,
                       input logic [31:0] d1, d2, imm, input logic src, input logic [3:0] op,
                       input logic mr, mw, rw);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_uses_rs2 = u2;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_src = src; id_alu_op = op;
        id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
    endtask

    task automatic fwd_in(input logic [4:0] er, input logic ew, input logic [31:0] ed,
                          input logic [4:0] mr, input logic mw, input logic [31:0] md);
        exmem_rd = er; exmem_reg_write = ew; exmem_result = ed;
        memwb_rd = mr; memwb_reg_write = mw; memwb_result = md;
    endtask

    initial begin
        reset = 1; hold = 0; flush = 0;
        fwd_in(0, 0, 0, 0, 0, 0);
        put($urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
            $urandom, $urandom, 4'($urandom), $urandom, $urandom, $urandom);
        tick();
        tick();
        check("reset_ex_valid", 128'(ex_valid), 0);
        check("reset_operation", 128'(Operation), 0);
        check("reset_srca", 128'(SrcA), 0);
        check("reset_srcb", 128'(SrcB), 0);
        check("reset_stall", 128'(stall_o), 0);
        reset = 0;

        // EX/MEM outranks MEM/WB, which outranks the register file
        put(1, 5, 0, 9, 0, 32'h11, 0, 0, 0, 4'h1, 0, 0, 1);
        tick();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fwd_in(5, 1, 32'hAA, 5, 1, 32'hBB);
        #1 check("fwd_exmem", 128'(SrcA), 32'hAA);
        exmem_reg_write = 0;
        #1 check("fwd_memwb", 128'(SrcA), 32'hBB);
        memwb_reg_write = 0;
        #1 check("fwd_none", 128'(SrcA), 32'h11);

        // x0 is never forwarded
        put(1, 0, 0, 9, 0, 0, 0, 0, 0, 4'h1, 0, 0, 1);
        fwd_in(0, 0, 0, 0, 0, 0);
        tick();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fwd_in(0, 1, 32'hDEAD, 0, 0, 0);
        #1 check("x0_exmem", 128'(SrcA), 0);
        fwd_in(0, 0, 0, 0, 1, 32'hDEAD);
        #1 check("x0_memwb", 128'(SrcA), 0);
        fwd_in(0, 0, 0, 0, 0, 0);

        // load-use: lw x7 then add x8, x1, x7
        put(1, 2, 0, 7, 0, 32'h100, 0, 4, 1, 4'h0, 1, 0, 1);
        tick();
        put(1, 1, 7, 8, 1, 32'h1, 32'h2, 0, 0, 4'h0, 0, 0, 1);
        #1 check("lu_stall", 128'(stall_o), 1);
        tick();
        check("lu_bubble_valid", 128'(ex_valid), 0);
        check("lu_stall_once", 128'(stall_o), 0);
        tick();
        check("lu_add_valid", 128'(ex_valid), 1);
        check("lu_add_rd", 128'(ex_rd), 8);

        // flush beats load-use
        put(1, 2, 0, 7, 0, 32'h100, 0, 4, 1, 4'h0, 1, 0, 1);
        tick();
        put(1, 1, 7, 8, 1, 32'h1, 32'h2, 0, 0, 4'h0, 0, 0, 1);
        flush = 1;
        #1 check("flush_no_stall", 128'(stall_o), 0);
        tick();
        flush = 0;
        check("flush_valid", 128'(ex_valid), 0);
        check("flush_reg_write", 128'(ex_reg_write), 0);

        // immediate overrides forwarded rs2 on SrcB but not on store data; then hold
        put(1, 1, 3, 4, 1, 32'h1, 32'h33, 32'hFFFF_FFFC, 1, 4'h2, 0, 1, 1);
        tick();
        fwd_in(3, 1, 32'h77, 0, 0, 0);
        put(1, 6, 6, 6, 0, 32'h5, 32'h5, 32'h5, 0, 4'h9, 0, 0, 1);
        #1 check("imm_srcb", 128'(SrcB), 32'hFFFF_FFFC);
        check("imm_store_fwd", 128'(ex_store_data), 32'h77);
        check("imm_op", 128'(Operation), 4'h2);
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            tick();
            check("hold_state", 128'({ex_valid, ex_rd, ex_mem_read, ex_mem_write, ex_reg_write, Operation}),
                  128'({1'b1, 5'd4, 1'b0, 1'b1, 1'b1, 4'h2}));
        end
        hold = 0; flush = 0;
        fwd_in(0, 0, 0, 0, 0, 0);

        // random traffic on a narrow register window so hazards collide often
        for (int i = 0; i < 300; i++) begin
            put($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom, $urandom,
                4'($urandom), $urandom_range(0, 2) == 0, $urandom, $urandom);
            fwd_in(5'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 3)), $urandom, $urandom);
            hold = $urandom_range(0, 7) == 0;
            flush = $urandom_range(0, 7) == 0;
            reset = $urandom_range(0, 63) == 0;
            tick();
        end
        reset = 0; hold = 0; flush = 0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
